// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_VGA = 1'b0,
        OWN_CPU = 1'b1
    } arb_owner_t;

    // VGA fetches always read the full word.
    localparam logic [3:0] BYTE_ALL = 4'b1111;

endpackage

// File: rtl/sram_arb_starve_ctr.sv
// Starvation guard: counts consecutive VGA grants made while the CPU is
// waiting and forces the next contested grant to the CPU at the limit.
module sram_arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic grant_vga,
    input  logic grant_cpu,
    input  logic cpu_req,
    output logic force_cpu
);
    import sram_arb_pkg::*;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] vga_streak_reg;

    // Streak of VGA wins against a pending CPU; any CPU win or uncontested VGA win restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_streak_reg <= 4'd0;
        end else if (grant_cpu || (grant_vga && !cpu_req)) begin
            vga_streak_reg <= 4'd0;
        end else if (grant_vga && (vga_streak_reg != 4'hF)) begin
            vga_streak_reg <= vga_streak_reg + 4'd1;
        end
    end

    assign force_cpu = (vga_streak_reg == LIMIT);

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for the single SRAM port: VGA fetcher (priority)
// and CPU data bus. Optional starvation guard enabled by defining
// SRAM_ARB_STARVE_GUARD_EN; without it VGA has strict priority.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic [31:0]       vga_rdata,
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_byte_sel,
    output logic              cpu_ack,
    output logic [31:0]       cpu_rdata,
    input  logic [31:0]       SRAM_data_in,
    input  logic              SRAM_busy,
    output logic [ADDR_W-1:0] word_address_dest,
    output logic [3:0]        byte_select,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [31:0]       mem_wdata,
    output logic [1:0]        arb_state,
    output logic              owner
);

    // Out-of-range limits would make the guard fire never or immediately.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("sram_arbiter: STARVE_LIMIT must be in 1..15");
    end

    arb_state_t        state_reg;
    arb_owner_t        owner_reg;
    logic              is_write_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [3:0]        byte_sel_reg;
    logic [31:0]       wdata_reg;
    logic              mem_ren_reg;
    logic              mem_wen_reg;
    logic              vga_ack_reg;
    logic              cpu_ack_reg;
    logic [31:0]       vga_rdata_reg;
    logic [31:0]       cpu_rdata_reg;

    logic force_cpu;
    logic pick_cpu;
    logic grant_vga;
    logic grant_cpu;
    logic grant_cpu_write;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    sram_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk       (clk),
        .rst       (rst),
        .grant_vga (grant_vga),
        .grant_cpu (grant_cpu),
        .cpu_req   (cpu_req),
        .force_cpu (force_cpu)
    );
`else
    assign force_cpu = 1'b0;
`endif

    // Grants are only decided in IDLE; VGA wins contested cycles unless the guard fires.
    assign pick_cpu        = cpu_req && (!vga_req || force_cpu);
    assign grant_cpu       = (state_reg == IDLE) && pick_cpu;
    assign grant_vga       = (state_reg == IDLE) && vga_req && !pick_cpu;
    assign grant_cpu_write = grant_cpu && cpu_wen;

    // Access sequencer: latch the winner, strobe once, wait out SRAM_busy, then ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            owner_reg     <= OWN_VGA;
            is_write_reg  <= 1'b0;
            addr_reg      <= '0;
            byte_sel_reg  <= 4'd0;
            wdata_reg     <= 32'd0;
            mem_ren_reg   <= 1'b0;
            mem_wen_reg   <= 1'b0;
            vga_ack_reg   <= 1'b0;
            cpu_ack_reg   <= 1'b0;
            vga_rdata_reg <= 32'd0;
            cpu_rdata_reg <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_vga || grant_cpu) begin
                        owner_reg    <= grant_cpu ? OWN_CPU : OWN_VGA;
                        addr_reg     <= grant_cpu ? cpu_addr : vga_addr;
                        byte_sel_reg <= grant_cpu ? cpu_byte_sel : BYTE_ALL;
                        wdata_reg    <= grant_cpu ? cpu_wdata : 32'd0;
                        is_write_reg <= grant_cpu_write;
                        mem_ren_reg  <= !grant_cpu_write;
                        mem_wen_reg  <= grant_cpu_write;
                        state_reg    <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_ren_reg <= 1'b0;
                    mem_wen_reg <= 1'b0;
                    state_reg   <= WAIT;
                end
                WAIT: begin
                    if (!SRAM_busy) begin
                        if (owner_reg == OWN_VGA) begin
                            vga_rdata_reg <= SRAM_data_in;
                            vga_ack_reg   <= 1'b1;
                        end else begin
                            if (!is_write_reg) begin
                                cpu_rdata_reg <= SRAM_data_in;
                            end
                            cpu_ack_reg <= 1'b1;
                        end
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    vga_ack_reg <= 1'b0;
                    cpu_ack_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign vga_ack           = vga_ack_reg;
    assign vga_rdata         = vga_rdata_reg;
    assign cpu_ack           = cpu_ack_reg;
    assign cpu_rdata         = cpu_rdata_reg;
    assign word_address_dest = addr_reg;
    assign byte_select       = byte_sel_reg;
    assign mem_ren           = mem_ren_reg;
    assign mem_wen           = mem_wen_reg;
    assign mem_wdata         = wdata_reg;
    assign arb_state         = state_reg;
    assign owner             = owner_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a 64-word SRAM model whose busy
// time after each strobe is set by busy_cfg.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int ADDR_W = 32;

    logic              tb_clk = 1'b0;
    logic              rst;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_ack;
    logic [31:0]       vga_rdata;
    logic              cpu_req;
    logic              cpu_wen;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_byte_sel;
    logic              cpu_ack;
    logic [31:0]       cpu_rdata;
    logic [31:0]       SRAM_data_in;
    logic              SRAM_busy;
    logic [ADDR_W-1:0] word_address_dest;
    logic [3:0]        byte_select;
    logic              mem_ren;
    logic              mem_wen;
    logic [31:0]       mem_wdata;
    logic [1:0]        arb_state;
    logic              owner;

    int checks = 0;
    int passed = 0;

    always #5 tb_clk = ~tb_clk;

    sram_arbiter #(
        .ADDR_W       (ADDR_W),
        .STARVE_LIMIT (4)
    ) dut (
        .clk               (tb_clk),
        .rst               (rst),
        .vga_req           (vga_req),
        .vga_addr          (vga_addr),
        .vga_ack           (vga_ack),
        .vga_rdata         (vga_rdata),
        .cpu_req           (cpu_req),
        .cpu_wen           (cpu_wen),
        .cpu_addr          (cpu_addr),
        .cpu_wdata         (cpu_wdata),
        .cpu_byte_sel      (cpu_byte_sel),
        .cpu_ack           (cpu_ack),
        .cpu_rdata         (cpu_rdata),
        .SRAM_data_in      (SRAM_data_in),
        .SRAM_busy         (SRAM_busy),
        .word_address_dest (word_address_dest),
        .byte_select       (byte_select),
        .mem_ren           (mem_ren),
        .mem_wen           (mem_wen),
        .mem_wdata         (mem_wdata),
        .arb_state         (arb_state),
        .owner             (owner)
    );

    // ---------------- SRAM model ----------------
    logic [31:0] mem [0:63];
    int busy_cfg = 0;
    int busy_cnt = 0;

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] lo;
        lo = 8'(i);
        return (i == 5) ? 32'h3FFFFFFC : {16'hA5A5, 8'h00, lo};
    endfunction

    always @(posedge tb_clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            busy_cnt <= 0;
        end else begin
            if (mem_wen) begin
                for (int b = 0; b < 4; b++)
                    if (byte_select[b])
                        mem[word_address_dest[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
            if (mem_ren || mem_wen) busy_cnt <= busy_cfg;
            else if (busy_cnt > 0)  busy_cnt <= busy_cnt - 1;
        end
    end

    assign SRAM_busy    = (busy_cnt != 0);
    assign SRAM_data_in = mem[word_address_dest[5:0]];

    // ---------------- protocol monitors ----------------
    int cyc = 0;
    int strobe_bad = 0;
    int both_ack = 0;
    int ren_pulses = 0;
    int wen_pulses = 0;
    int cpu_acks = 0;

    always @(posedge tb_clk) cyc <= cyc + 1;

    always @(negedge tb_clk) begin
        if ((mem_ren || mem_wen) && arb_state != 2'd1) strobe_bad <= strobe_bad + 1;
        if (vga_ack && cpu_ack) both_ack <= both_ack + 1;
        if (mem_ren) ren_pulses <= ren_pulses + 1;
        if (mem_wen) wen_pulses <= wen_pulses + 1;
        if (cpu_ack) cpu_acks <= cpu_acks + 1;
    end

    // Bounded wait for the next ack (no checking inside).
    task automatic wait_ack(input int limit, output bit got, output bit was_cpu);
        got = 1'b0;
        was_cpu = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge tb_clk);
            if (vga_ack || cpu_ack) begin
                got = 1'b1;
                was_cpu = cpu_ack;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [180:0] outs;
        outs = {vga_ack, vga_rdata, cpu_ack, cpu_rdata, word_address_dest, byte_select,
                mem_ren, mem_wen, mem_wdata, arb_state, owner};
        checks++;
        if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs);
        else passed++;
        rst = 1'b0;
        @(negedge tb_clk);
        @(negedge tb_clk);
        checks++;
        if (arb_state !== 2'd0 || mem_ren !== 1'b0)
            $display("FAIL reset_idle: state=%0d ren=%b want state=0 ren=0", arb_state, mem_ren);
        else passed++;
        $display("reset: state=%0d", arb_state);
    endtask

    task automatic test_vga_read;
        int ren0;
        vga_addr = 32'd5;
        vga_req  = 1'b1;
        ren0 = ren_pulses;
        @(negedge tb_clk);
        checks++;
        if (mem_ren !== 1'b1 || arb_state !== 2'd1 || word_address_dest !== 32'd5 || byte_select !== 4'hF)
            $display("FAIL vga_issue: ren=%b state=%0d addr=%0d lanes=%h want 1/1/5/f",
                     mem_ren, arb_state, word_address_dest, byte_select);
        else passed++;
        @(negedge tb_clk);
        checks++;
        if (mem_ren !== 1'b0 || arb_state !== 2'd2)
            $display("FAIL vga_wait: ren=%b state=%0d want 0/2", mem_ren, arb_state);
        else passed++;
        @(negedge tb_clk);
        checks++;
        if (vga_ack !== 1'b1 || vga_rdata !== 32'h3FFFFFFC || owner !== 1'b0)
            $display("FAIL vga_ack: ack=%b rdata=%h owner=%b want 1/3ffffffc/0", vga_ack, vga_rdata, owner);
        else passed++;
        vga_req = 1'b0;
        @(negedge tb_clk);
        checks++;
        if (vga_ack !== 1'b0 || arb_state !== 2'd0 || ren_pulses - ren0 != 1)
            $display("FAIL vga_after: ack=%b state=%0d ren_pulses=%0d want 0/0/1",
                     vga_ack, arb_state, ren_pulses - ren0);
        else passed++;
        $display("vga_read: addr=5 rdata=%h", vga_rdata);
    endtask

    task automatic test_cpu_write;
        int n;
        int wen0;
        busy_cfg     = 3;
        cpu_addr     = 32'd52;
        cpu_wdata    = 32'hFFFFFFFF;
        cpu_byte_sel = 4'b0011;
        cpu_wen      = 1'b1;
        cpu_req      = 1'b1;
        wen0 = wen_pulses;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge tb_clk);
            n++;
            if (n == 1) begin
                checks++;
                if (mem_wen !== 1'b1 || mem_ren !== 1'b0 || byte_select !== 4'b0011 || mem_wdata !== 32'hFFFFFFFF)
                    $display("FAIL cpu_wr_issue: wen=%b ren=%b lanes=%b wdata=%h want 1/0/0011/ffffffff",
                             mem_wen, mem_ren, byte_select, mem_wdata);
                else passed++;
            end
            if (cpu_ack) break;
        end
        checks++;
        if (n != 6 || cpu_ack !== 1'b1)
            $display("FAIL cpu_wr_latency: ack after %0d cycles ack=%b want 6", n, cpu_ack);
        else passed++;
        cpu_req  = 1'b0;
        busy_cfg = 0;
        @(negedge tb_clk);
        checks++;
        if (mem[52] !== 32'hA5A5FFFF || wen_pulses - wen0 != 1)
            $display("FAIL cpu_wr_data: mem52=%h wen_pulses=%0d want a5a5ffff/1", mem[52], wen_pulses - wen0);
        else passed++;
        $display("cpu_write: addr=52 mem=%h latency=%0d", mem[52], n);
    endtask

    task automatic test_cpu_read;
        bit got, was_cpu;
        cpu_addr = 32'd5;
        cpu_wen  = 1'b0;
        cpu_req  = 1'b1;
        wait_ack(10, got, was_cpu);
        cpu_req = 1'b0;
        checks++;
        if (!got || !was_cpu || cpu_rdata !== 32'h3FFFFFFC || owner !== 1'b1 || vga_rdata !== 32'h3FFFFFFC)
            $display("FAIL cpu_read: got=%b cpu=%b rdata=%h owner=%b want 1/1/3ffffffc/1",
                     got, was_cpu, cpu_rdata, owner);
        else passed++;
        @(negedge tb_clk);
        $display("cpu_read: addr=5 rdata=%h", cpu_rdata);
    endtask

    task automatic test_simultaneous;
        bit got, was_cpu, exp_cpu;
        int cpu0;
        vga_addr = 32'd7;
        cpu_addr = 32'd9;
        cpu_wen  = 1'b0;
        cpu0     = cpu_acks;
        vga_req  = 1'b1;
        cpu_req  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wait_ack(10, got, was_cpu);
`ifdef SRAM_ARB_STARVE_GUARD_EN
            exp_cpu = ((i % 5) == 4);
`else
            exp_cpu = 1'b0;
`endif
            checks++;
            if (!got || was_cpu !== exp_cpu) begin
                $display("FAIL contest_grant%0d: got=%b cpu=%b want got=1 cpu=%b", i, got, was_cpu, exp_cpu);
                if (!got) break;
            end else passed++;
            $display("contest: grant %0d to %s", i, was_cpu ? "CPU" : "VGA");
        end
        vga_req = 1'b0;
        cpu_req = 1'b0;
        @(negedge tb_clk);
`ifndef SRAM_ARB_STARVE_GUARD_EN
        checks++;
        if (cpu_acks - cpu0 != 0)
            $display("FAIL contest_no_cpu: cpu acks=%0d want 0", cpu_acks - cpu0);
        else passed++;
`endif
        @(negedge tb_clk);
    endtask

    task automatic test_back_to_back;
        bit got, was_cpu;
        int last;
        vga_addr = 32'd0;
        vga_req  = 1'b1;
        last = 0;
        for (int i = 0; i < 10; i++) begin
            wait_ack(10, got, was_cpu);
            checks++;
            if (!got || was_cpu || vga_rdata !== init_word(i) || (i > 0 && cyc - last != 4))
                $display("FAIL burst%0d: got=%b rdata=%h gap=%0d want rdata=%h gap=4",
                         i, got, vga_rdata, cyc - last, init_word(i));
            else passed++;
            $display("burst: addr=%0d rdata=%h gap=%0d", i, vga_rdata, cyc - last);
            last = cyc;
            if (!got) break;
            if (i < 9) vga_addr = 32'(i + 1);
            else       vga_req = 1'b0;
        end
        vga_req = 1'b0;
        @(negedge tb_clk);
    endtask

    task automatic test_reset_mid_wait;
        logic [180:0] outs;
        int acks0;
        busy_cfg = 100;
        cpu_addr = 32'd3;
        cpu_wen  = 1'b0;
        cpu_req  = 1'b1;
        repeat (3) @(negedge tb_clk);
        checks++;
        if (arb_state !== 2'd2)
            $display("FAIL rst_pre_wait: state=%0d want 2", arb_state);
        else passed++;
        #2 rst = 1'b1;
        #1;
        outs = {vga_ack, vga_rdata, cpu_ack, cpu_rdata, word_address_dest, byte_select,
                mem_ren, mem_wen, mem_wdata, arb_state, owner};
        checks++;
        if (outs !== '0) $display("FAIL rst_async: outputs=%h want 0", outs);
        else passed++;
        cpu_req = 1'b0;
        @(negedge tb_clk);
        rst = 1'b0;
        busy_cfg = 0;
        acks0 = cpu_acks;
        repeat (10) @(negedge tb_clk);
        checks++;
        if (cpu_acks - acks0 != 0 || arb_state !== 2'd0)
            $display("FAIL rst_no_ack: acks=%0d state=%0d want 0/0", cpu_acks - acks0, arb_state);
        else passed++;
        $display("reset_mid_wait: state=%0d", arb_state);
    endtask

    task automatic test_protocol;
        checks++;
        if (strobe_bad != 0)
            $display("FAIL strobe_outside_issue: count=%0d want 0", strobe_bad);
        else passed++;
        checks++;
        if (both_ack != 0)
            $display("FAIL dual_ack: count=%0d want 0", both_ack);
        else passed++;
    endtask

    initial begin
        rst = 1'b1;
        vga_req = 1'b0; vga_addr = '0;
        cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_byte_sel = '0;
        repeat (3) @(negedge tb_clk);
        test_reset;
        test_vga_read;
        test_cpu_write;
        test_cpu_read;
        test_simultaneous;
        test_back_to_back;
        test_reset_mid_wait;
        test_protocol;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the single SRAM port between the VGA frame fetcher (`VGA_out`) and the CPU data bus. The VGA requester is real-time and wins by default; the CPU is served between VGA fetches, with an optional starvation guard. It sits between both requesters and the SRAM model/controller and owns `word_address_dest`, `byte_select` and the read/write strobes.

## Interface
Parameters:
- `ADDR_W`, 32, address width on all ports.
- `STARVE_LIMIT`, 4, consecutive VGA grants while `cpu_req` is pending before the CPU is forced in; legal range 1–15.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `vga_req`  in  1  VGA read request; held until `vga_ack`.
- `vga_addr`  in  ADDR_W  VGA word address; stable while `vga_req` is high.
- `vga_ack`  out  1  one-cycle completion pulse.
- `vga_rdata`  out  32  read word; valid while `vga_ack` is high, held until the next VGA completion.
- `cpu_req`  in  1  CPU request; held until `cpu_ack`.
- `cpu_wen`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  CPU word address.
- `cpu_wdata`  in  32  write data.
- `cpu_byte_sel`  in  4  byte lanes for writes.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  32  read word; valid while `cpu_ack` is high, held until the next CPU completion.
- `SRAM_data_in`  in  32  SRAM read data.
- `SRAM_busy`  in  1  SRAM access in progress.
- `word_address_dest`  out  ADDR_W  SRAM address.
- `byte_select`  out  4  SRAM byte lanes.
- `mem_ren`  out  1  read strobe.
- `mem_wen`  out  1  write strobe.
- `mem_wdata`  out  32  SRAM write data.
- `arb_state`  out  2  current FSM state (debug).
- `owner`  out  1  0 = VGA, 1 = CPU; the requester of the current or last access.

## Operation
- FSM states: IDLE (0), ISSUE (1), WAIT (2), DONE (3). All outputs are registered.
- IDLE: at the clock edge, sample `vga_req` and `cpu_req`.
  - If neither is high, stay in IDLE.
  - Otherwise select a winner, latch its address and, for the CPU, `cpu_wdata`, `cpu_byte_sel` and `cpu_wen`. Go to ISSUE.
- Winner selection:
  - VGA only → VGA.
  - CPU only → CPU.
  - Both → VGA, unless the starvation guard fires (see Configuration).
- ISSUE: drive `mem_ren` or `mem_wen` high for exactly this one cycle, together with the address, lanes and data. Go to WAIT.
  - A VGA access is always a read with `byte_select` = 4'b1111.
- WAIT: hold the address, lanes and data.
  - `SRAM_busy` = 1 → stay in WAIT.
  - `SRAM_busy` = 0 → capture `SRAM_data_in` into the winner's rdata register (reads only) and go to DONE.
  - There is no timeout.
- DONE: pulse the winner's ack for one cycle; requests are ignored. Go to IDLE.
- Requester rule: deassert `req` by the edge that ends the ack cycle. A request still high in IDLE is treated as a new access.
- Reset, including mid-access: all outputs go to 0, state goes to IDLE, the streak counter clears, and any in-flight access is abandoned with no ack.

## Timing
- Minimum latency: request high before edge k → ISSUE in cycle k+1 → WAIT in cycle k+2 → ack in cycle k+3 (when `SRAM_busy` = 0 in WAIT).
- Each busy cycle in WAIT adds one cycle of latency.
- Back-to-back accesses: IDLE, ISSUE, WAIT, DONE gives a minimum of 4 cycles per access.
- Strobes are never high outside ISSUE. `vga_ack` and `cpu_ack` are never high in the same cycle.

## Configuration
- Macro: `SRAM_ARB_STARVE_GUARD_EN`.
- Defined:
  - A counter `vga_streak` (4 bits) increments on each VGA grant made while `cpu_req` is high.
  - It clears on any CPU grant, and on any VGA grant made while `cpu_req` is low.
  - When both requests are high and `vga_streak` == `STARVE_LIMIT`, the CPU wins.
- Undefined: strict VGA priority; the counter logic is absent.

## Structure
- Package `sram_arb_pkg` holds:
  - `arb_state_t` enum {IDLE, ISSUE, WAIT, DONE}.
  - `arb_owner_t` enum {OWN_VGA, OWN_CPU}.
  - `BYTE_ALL` = 4'b1111.
- Sub-module `sram_arb_starve_ctr` holds the streak counter and the force-CPU compare. It is instantiated only under the macro.

## Test plan
- Reset: assert `rst` mid-WAIT → all outputs 0 and `arb_state` = 0 immediately; no ack after release.
- VGA read: `vga_addr` = 5, memory[5] = 32'h3FFFFFFC, `SRAM_busy` = 0 → `mem_ren` high exactly in cycle k+1; `vga_ack` in cycle k+3 with `vga_rdata` = 32'h3FFFFFFC.
- CPU write with busy: `cpu_addr` = 52, `cpu_wdata` = 32'hFFFFFFFF, lanes 4'b0011, `SRAM_busy` high for 3 cycles → `mem_wen` pulses once; `cpu_ack` at k+6; memory[52] lanes 0–1 updated.
- Simultaneous requests, macro off: both held continuously for 20 accesses → every grant goes to VGA and `cpu_ack` never fires.
- Starvation, macro on, `STARVE_LIMIT` = 4: both held → grant order VGA, VGA, VGA, VGA, CPU, repeating.
- Burst: `vga_req` re-raised immediately after each ack for 10 reads of addresses 0–9 → one ack every 4 cycles with correct data.
